// File: rtl/async_fifo_wr_ctrl.sv
// Write-domain controller of a dual-clock FIFO. It accepts producer words and drives the SRAM write port.
// It publishes a Gray write pointer and derives conservative full/almost_full/level from the synchronized read pointer.
module async_fifo_wr_ctrl #(
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 12
) (
    input  logic                  wclk,
    input  logic                  rst,
    input  logic                  w_valid,
    output logic                  w_ready,
    input  logic [DATA_WIDTH-1:0] w_data_in,
    input  logic [ADDR_WIDTH:0]   rptr_gray,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    output logic                  sram_w_en,
    output logic [ADDR_WIDTH-1:0] sram_w_addr,
    output logic [DATA_WIDTH-1:0] sram_w_data,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   level
);

    localparam int PW = ADDR_WIDTH + 1;
    // Full when the write pointer is exactly one lap ahead: the top two Gray bits differ, the rest match.
    localparam logic [PW-1:0] FULL_MASK = PW'(3) << (ADDR_WIDTH - 1);

    logic [PW-1:0]                  wbin;
    logic [PW-1:0]                  wbin_next;
    logic [PW-1:0]                  wgray_next;
    logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
    logic [PW-1:0]                  rq;
    logic [PW-1:0]                  rbin_sync;
    logic [PW-1:0]                  level_next;
    logic                           accept;
    logic                           full_next;
    logic                           afull_next;

    assign w_ready     = !full && !rst;
    assign accept      = w_valid && w_ready;
    assign sram_w_en   = accept;
    assign sram_w_addr = wbin[ADDR_WIDTH-1:0];
    assign sram_w_data = w_data_in;

    assign wbin_next  = wbin + {{ADDR_WIDTH{1'b0}}, accept};
    assign wgray_next = wbin_next ^ (wbin_next >> 1);
    assign rq         = sync_q[SYNC_STAGES-1];

    // NOTE: every variable assigned in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        rbin_sync = '0;
        for (int i = 0; i < PW; i++) begin
            rbin_sync[i] = ^(rq >> i);
        end
    end

    // Stale rq only lags the real read pointer, so level can overestimate but never underestimate.
    assign level_next = wbin_next - rbin_sync;
    assign full_next  = (wgray_next == (rq ^ FULL_MASK));
    assign afull_next = (level_next >= PW'(AFULL_THRESH));

    // NOTE: synchronizer flops are reset too; a stale nonzero rq after reset would fake a nonzero level.
    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= rptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            wbin        <= '0;
            wptr_gray   <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            level       <= '0;
        end else begin
            wbin        <= wbin_next;
            wptr_gray   <= wgray_next;
            full        <= full_next;
            almost_full <= afull_next;
            level       <= level_next;
        end
    end

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Bench for async_fifo_wr_ctrl: SRAM writes go through a scoreboard queue checked by a monitor;
// status outputs are checked against hand-derived values after each edge.
module tb_async_fifo_wr_ctrl;

    localparam int AW = 4;
    localparam int DW = 4;
    localparam int PW = AW + 1;

    logic          wclk;
    logic          rst;
    logic          w_valid;
    logic          w_ready;
    logic [DW-1:0] w_data_in;
    logic [PW-1:0] rptr_gray;
    logic [PW-1:0] wptr_gray;
    logic          sram_w_en;
    logic [AW-1:0] sram_w_addr;
    logic [DW-1:0] sram_w_data;
    logic          full;
    logic          almost_full;
    logic [PW-1:0] level;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           sb[$];
    wr_t           mon_exp;
    int            n_tests  = 0;
    int            n_failed = 0;
    logic [PW-1:0] exp_wbin;
    logic [PW-1:0] prev_g;

    async_fifo_wr_ctrl #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .SYNC_STAGES (2),
        .AFULL_THRESH(12)
    ) dut (
        .wclk       (wclk),
        .rst        (rst),
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .w_data_in  (w_data_in),
        .rptr_gray  (rptr_gray),
        .wptr_gray  (wptr_gray),
        .sram_w_en  (sram_w_en),
        .sram_w_addr(sram_w_addr),
        .sram_w_data(sram_w_data),
        .full       (full),
        .almost_full(almost_full),
        .level      (level)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // One cycle of stimulus; an expected accept pushes its SRAM write into the scoreboard.
    task automatic write_word(input logic [DW-1:0] d, input bit exp_acc);
        w_valid   = 1'b1;
        w_data_in = d;
        if (exp_acc) begin
            sb.push_back({exp_wbin[AW-1:0], d});
            exp_wbin = exp_wbin + 1'b1;
        end
        @(posedge wclk);
        #1;
        w_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge wclk);
            #1;
        end
    endtask

    // Monitor: mid-cycle, any SRAM write must match the oldest expected write.
    always @(negedge wclk) begin
        if (sram_w_en) begin
            if (sb.size() == 0) begin
                check("sram_unexpected_write", 32'(sram_w_en), 32'(0));
            end else begin
                mon_exp = sb.pop_front();
                check("sram_addr", 32'(sram_w_addr), 32'(mon_exp.addr));
                check("sram_data", 32'(sram_w_data), 32'(mon_exp.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        w_valid   = 1'b1;
        w_data_in = 4'hA;
        rptr_gray = '0;
        exp_wbin  = '0;

        // Reset with w_valid held high
        idle(2);
        check("rst_w_ready", 32'(w_ready), 32'(0));
        check("rst_sram_w_en", 32'(sram_w_en), 32'(0));
        check("rst_wptr_gray", 32'(wptr_gray), 32'(0));
        check("rst_level", 32'(level), 32'(0));
        check("rst_full", 32'(full), 32'(0));
        w_valid = 1'b0;
        rst     = 1'b0;
        #1;
        check("rel_w_ready", 32'(w_ready), 32'(1));
        idle(1);

        // Fill 16 words with rptr at 0
        for (int k = 1; k <= 16; k++) begin
            write_word(DW'(k - 1), 1'b1);
            check("fill_level", 32'(level), 32'(k));
            check("fill_afull", 32'(almost_full), 32'(k >= 12));
            check("fill_full", 32'(full), 32'(k == 16));
        end
        check("full_w_ready", 32'(w_ready), 32'(0));
        write_word(4'hF, 1'b0);
        check("full_blocked_wptr", 32'(wptr_gray), 32'(5'b11000));
        check("full_blocked_level", 32'(level), 32'(16));

        // Drain visibility: read pointer jumps to 4, seen after exactly 3 edges
        rptr_gray = 5'b00110;
        idle(1);
        check("drain_e1_full", 32'(full), 32'(1));
        idle(1);
        check("drain_e2_full", 32'(full), 32'(1));
        check("drain_e2_level", 32'(level), 32'(16));
        idle(1);
        check("drain_e3_full", 32'(full), 32'(0));
        check("drain_e3_level", 32'(level), 32'(12));
        check("drain_e3_w_ready", 32'(w_ready), 32'(1));
        check("drain_e3_afull", 32'(almost_full), 32'(1));

        // Wrap: read pointer tracks the write pointer across 40 accepts
        rptr_gray = gray(exp_wbin);
        idle(3);
        check("wrap_start_level", 32'(level), 32'(0));
        for (int i = 0; i < 40; i++) begin
            prev_g = gray(exp_wbin);
            write_word(i[3:0], 1'b1);
            check("wrap_gray", 32'(wptr_gray), 32'(gray(exp_wbin)));
            check("wrap_onebit", 32'($countones(wptr_gray ^ prev_g)), 32'(1));
            check("wrap_level", 32'(level), 32'(1));
            rptr_gray = gray(exp_wbin);
            idle(3);
        end

        // Simultaneous: level 15, then accept on the edge that reflects rptr advancing by 2
        for (int i = 0; i < 15; i++) begin
            write_word(DW'(i + 3), 1'b1);
        end
        check("simul_pre_level", 32'(level), 32'(15));
        check("simul_pre_full", 32'(full), 32'(0));
        rptr_gray = 5'b10111;
        idle(2);
        check("simul_mid_level", 32'(level), 32'(15));
        write_word(4'h5, 1'b1);
        check("simul_level", 32'(level), 32'(14));
        check("simul_full", 32'(full), 32'(0));

        // Reset mid-stream after 7 accepts
        rptr_gray = gray(exp_wbin);
        idle(3);
        check("mid_start_level", 32'(level), 32'(0));
        for (int i = 0; i < 7; i++) begin
            write_word(DW'(9 - i), 1'b1);
        end
        check("mid_pre_level", 32'(level), 32'(7));
        check("mid_pre_wptr", 32'(wptr_gray), 32'(5'b01000));
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_level", 32'(level), 32'(0));
        check("mid_rst_full", 32'(full), 32'(0));
        check("mid_rst_wptr", 32'(wptr_gray), 32'(0));
        check("mid_rst_w_ready", 32'(w_ready), 32'(0));
        exp_wbin  = '0;
        rptr_gray = '0;
        idle(1);
        rst = 1'b0;
        #1;
        check("mid_rel_w_ready", 32'(w_ready), 32'(1));
        write_word(4'hC, 1'b1);
        check("mid_after_wptr", 32'(wptr_gray), 32'(1));
        check("mid_after_level", 32'(level), 32'(1));

        idle(2);
        check("sb_empty", 32'(sb.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
